// File: rtl/vga_scan_driver.sv
// rtl/vga_scan_driver.sv - VGA timing generator with pipeline-aligned sync and blanked RGB
module vga_scan_driver #(
    parameter int H_ACTIVE     = 640,
    parameter int H_FP         = 16,
    parameter int H_SYNC       = 96,
    parameter int H_BP         = 48,
    parameter int V_ACTIVE     = 480,
    parameter int V_FP         = 10,
    parameter int V_SYNC       = 2,
    parameter int V_BP         = 33,
    parameter int DATA_LATENCY = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] VGA_data,
    output logic [10:0] VGA_xpos,
    output logic [10:0] VGA_ypos,
    output logic        frame_start,
    output logic        VGA_hs,
    output logic        VGA_vs,
    output logic [3:0]  VGA_r,
    output logic [3:0]  VGA_g,
    output logic [3:0]  VGA_b
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] H_LAST      = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST      = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_SYNC_END  = 11'(H_SYNC);
    localparam logic [10:0] V_SYNC_END  = 11'(V_SYNC);
    localparam logic [10:0] H_ACT_START = 11'(H_SYNC + H_BP);
    localparam logic [10:0] H_ACT_END   = 11'(H_SYNC + H_BP + H_ACTIVE);
    localparam logic [10:0] V_ACT_START = 11'(V_SYNC + V_BP);
    localparam logic [10:0] V_ACT_END   = 11'(V_SYNC + V_BP + V_ACTIVE);
    localparam logic [10:0] X_OFFSET    = 11'(H_SYNC + H_BP - 1);
    localparam logic [10:0] Y_OFFSET    = 11'(V_SYNC + V_BP - 1);

    logic [10:0] h_cnt_q, h_cnt_d;
    logic [10:0] v_cnt_q, v_cnt_d;
    logic [10:0] xpos_q, xpos_d;
    logic [10:0] ypos_q, ypos_d;
    logic        frame_start_q, frame_start_d;

    // Index 0 sits in the coordinate stage; indices 1..DATA_LATENCY are the alignment stages.
    logic [DATA_LATENCY:0] hs_dly_q, hs_dly_d;
    logic [DATA_LATENCY:0] vs_dly_q, vs_dly_d;
    logic [DATA_LATENCY:0] de_dly_q, de_dly_d;

    logic        hs_out_q, hs_out_d;
    logic        vs_out_q, vs_out_d;
    logic [11:0] rgb_q, rgb_d;

    logic raw_hs, raw_vs, raw_de, h_win, v_win;

    always_comb begin
        h_cnt_d = h_cnt_q + 11'd1;
        v_cnt_d = v_cnt_q;
        if (h_cnt_q == H_LAST) begin
            h_cnt_d = '0;
            v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 11'd1;
        end

        raw_hs = (h_cnt_q >= H_SYNC_END);
        raw_vs = (v_cnt_q >= V_SYNC_END);
        h_win  = (h_cnt_q >= H_ACT_START) && (h_cnt_q < H_ACT_END);
        v_win  = (v_cnt_q >= V_ACT_START) && (v_cnt_q < V_ACT_END);
        raw_de = h_win && v_win;

        xpos_d        = raw_de ? (h_cnt_q - X_OFFSET) : '0;
        ypos_d        = raw_de ? (v_cnt_q - Y_OFFSET) : '0;
        frame_start_d = (h_cnt_q == '0) && (v_cnt_q == '0);

        hs_dly_d = {hs_dly_q[DATA_LATENCY-1:0], raw_hs};
        vs_dly_d = {vs_dly_q[DATA_LATENCY-1:0], raw_vs};
        de_dly_d = {de_dly_q[DATA_LATENCY-1:0], raw_de};

        // Generator data lines up with the last alignment stage; blank it outside the window.
        hs_out_d = hs_dly_q[DATA_LATENCY];
        vs_out_d = vs_dly_q[DATA_LATENCY];
        rgb_d    = de_dly_q[DATA_LATENCY] ? VGA_data : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            xpos_q        <= '0;
            ypos_q        <= '0;
            frame_start_q <= 1'b0;
            hs_dly_q      <= '1;
            vs_dly_q      <= '1;
            de_dly_q      <= '0;
            hs_out_q      <= 1'b1;
            vs_out_q      <= 1'b1;
            rgb_q         <= '0;
        end else begin
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            xpos_q        <= xpos_d;
            ypos_q        <= ypos_d;
            frame_start_q <= frame_start_d;
            hs_dly_q      <= hs_dly_d;
            vs_dly_q      <= vs_dly_d;
            de_dly_q      <= de_dly_d;
            hs_out_q      <= hs_out_d;
            vs_out_q      <= vs_out_d;
            rgb_q         <= rgb_d;
        end
    end

    assign VGA_xpos    = xpos_q;
    assign VGA_ypos    = ypos_q;
    assign frame_start = frame_start_q;
    assign VGA_hs      = hs_out_q;
    assign VGA_vs      = vs_out_q;
    assign VGA_r       = rgb_q[11:8];
    assign VGA_g       = rgb_q[7:4];
    assign VGA_b       = rgb_q[3:0];

endmodule

// File: doc/vga_scan_driver.md
# vga_scan_driver

VGA scan driver for the 640x480@60 Hz display path. It generates the horizontal and vertical timing and publishes the current pixel coordinate as `VGA_xpos`/`VGA_ypos`, which the picture generators (game interface, start show, game-over overlay) consume. It takes back their registered `VGA_data`, blanks it outside the visible area and drives the RGB and sync pins. Sync is delayed to match the generators' pipeline latency, so colour and sync leave the block aligned.

## Interface
- `H_ACTIVE`, 640, visible pixels per line
- `H_FP`, 16, horizontal front porch (pixels)
- `H_SYNC`, 96, horizontal sync width (pixels)
- `H_BP`, 48, horizontal back porch (pixels)
- `V_ACTIVE`, 480, visible lines
- `V_FP`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vertical sync width (lines)
- `V_BP`, 33, vertical back porch (lines)
- `DATA_LATENCY`, 3, cycles from a coordinate on `VGA_xpos`/`VGA_ypos` to its pixel on `VGA_data`; legal range 1..8

Ports:
- `clk` in 1: pixel clock, 25 MHz; one pixel per cycle
- `rst` in 1: synchronous, active-high reset
- `VGA_data` in 12: pixel from the generators, {R[11:8], G[7:4], B[3:0]}
- `VGA_xpos` out 11: 1..640 inside the visible area, 0 elsewhere
- `VGA_ypos` out 11: 1..480 inside the visible area, 0 elsewhere
- `frame_start` out 1: one-cycle pulse in the coordinate stage when the counters were at (0,0)
- `VGA_hs` out 1: horizontal sync, active low
- `VGA_vs` out 1: vertical sync, active low
- `VGA_r`, `VGA_g`, `VGA_b` out 4 each: colour to the DAC

## Operation
- H_TOTAL = 800 and V_TOTAL = 525. These are the sums of the parameters.
- Horizontal counter `h_cnt`:
  - Counts 0..H_TOTAL-1 and wraps to 0.
- Vertical counter `v_cnt`:
  - Increments only on the cycle where `h_cnt` = H_TOTAL-1.
  - Wraps from V_TOTAL-1 to 0 on that same cycle.
- Line order: sync, back porch, active, front porch.
  - Raw hsync is low while `h_cnt` < H_SYNC.
  - Raw vsync is low while `v_cnt` < V_SYNC.
- Horizontal active window: `h_cnt` in [H_SYNC+H_BP, H_SYNC+H_BP+H_ACTIVE), which is [144, 784).
- Vertical active window: `v_cnt` in [V_SYNC+V_BP, V_SYNC+V_BP+V_ACTIVE), which is [35, 515).
- Raw `de` is the AND of the horizontal and vertical active windows.
- Coordinate stage (registered from the counters):
  - `VGA_xpos` = h_cnt-143 and `VGA_ypos` = v_cnt-34 when raw de = 1.
  - Both are 0 when raw de = 0.
  - Subtraction is done in 11 bits and never goes negative inside the window.
- Alignment pipeline: raw hsync, raw vsync and raw de pass through DATA_LATENCY shift stages, then one output register.
- Output register:
  - `VGA_hs` and `VGA_vs` take the delayed sync values.
  - RGB = delayed de ? `VGA_data` split into nibbles : 0.
  - `VGA_data` is ignored whenever delayed de = 0.
- Reset, in any cycle:
  - Counters go to 0 and all delay stages go to the inactive state (sync 1, de 0).
  - Outputs go to: `VGA_xpos` = 0, `VGA_ypos` = 0, `frame_start` = 0, `VGA_hs` = 1, `VGA_vs` = 1, RGB = 0.
- Reset mid-frame abandons the frame immediately. No partial-line completion.

## Timing
- Coordinate stage: the counter value at edge N appears on `VGA_xpos`/`VGA_ypos`/`frame_start` after edge N.
- Sync/RGB: the same pixel's `VGA_hs`, `VGA_vs` and RGB appear DATA_LATENCY+1 cycles after its coordinate.
- Data sampling: `VGA_data` is sampled exactly DATA_LATENCY cycles after the matching coordinate.
- After reset release:
  - First edge: the coordinate stage shows (0,0) and `frame_start` = 1 for one cycle.
  - `VGA_hs` first goes low DATA_LATENCY+1 cycles after that.
- Line period is 800 cycles; `VGA_hs` low for 96 of them.
- Frame period is 420000 cycles; `VGA_vs` low for 1600 of them.
- `VGA_vs` edges coincide with the `VGA_hs` falling edge (both derived from h_cnt = 0).
- `VGA_xpos` per line: 0 for 144 coordinate cycles, 1..640 consecutively, then 0 for 16.
- `VGA_ypos` steps once per line, at the same cycle `VGA_xpos` leaves 0.
- Both coordinates are held at 0 on all non-visible lines.

## Test plan
- Reset:
  - Stimulus: hold `rst` for 5 cycles with `VGA_data` = 12'hFFF.
  - Required: `VGA_hs` = `VGA_vs` = 1; RGB, xpos, ypos and `frame_start` = 0 throughout.
  - Required after release: `frame_start` pulses exactly one cycle later.
- Horizontal timing:
  - Stimulus: run 3 lines.
  - Required: `VGA_hs` falling edges 800 cycles apart, low width 96.
  - Required: first `VGA_xpos` = 1 occurs 144 coordinate cycles after the `frame_start` line begins (first visible line only).
- Vertical timing:
  - Stimulus: run 2 frames.
  - Required: `frame_start` 420000 cycles apart; `VGA_vs` low 1600 cycles per frame.
  - Required: `VGA_ypos` runs 1..480, then 0 for 45 lines.
- Data alignment:
  - Stimulus: bench model returns `VGA_data` = {xpos[3:0], ypos[3:0], 4'hA} delayed 3 cycles.
  - Required: each visible output pixel matches its coordinate.
  - Required: the pixel at xpos = 640 is followed by RGB = 0 on the next cycle.
- Blanking:
  - Stimulus: force `VGA_data` = 12'hFFF constantly.
  - Required: RGB is nonzero for exactly 640×480 cycles per frame, never while `VGA_hs` or `VGA_vs` is low.
- Mid-frame reset:
  - Stimulus: assert `rst` for 1 cycle at line 200, xpos 300.
  - Required: outputs return to reset values next cycle.
  - Required: a new frame begins with `frame_start`, and timing matches the reset scenario.
